fp_addsub_special_pipe: RTL and testbench

Parametrised, pipelined special-operand handler for the IEEE-754 add/sub datapath. It classifies both operands (zero, infinity, quiet/signalling NaN) and resolves the result whenever one applies. It flags the result as special so the main adder output is bypassed. It generalises the single-precision, zero-only, combinational zero handler: any format, full special-value coverage, rounding-mode-aware zero sign, valid/ready pipeline and a statistics counter.

---
 rtl/fp_special_pkg.sv | 31 +++
 rtl/fp_classify.sv | 42 ++++
 rtl/fp_addsub_special_pipe.sv | 157 +++++++++++++++
 tb/tb_fp_addsub_special_pipe.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_special_pkg.sv
// Shared types and helpers for the add/sub special-operand handler.
// Combinational only: constants, operand class enum and canonical qNaN builder.
// No flow control in this file.
package fp_special_pkg;

    // Rounding modes as carried on in_rm.
    localparam logic [1:0] RM_RNE = 2'd0;
    localparam logic [1:0] RM_RTZ = 2'd1;
    localparam logic [1:0] RM_RDN = 2'd2;
    localparam logic [1:0] RM_RUP = 2'd3;

    typedef enum logic [2:0] {
        CLS_NORM,
        CLS_ZERO,
        CLS_INF,
        CLS_QNAN,
        CLS_SNAN
    } fp_class_e;

    localparam int QNAN_MAX_W = 128;

    // Canonical quiet NaN: sign 0, exponent all ones, mantissa MSB 1, rest 0.
    // Built in a wide vector; callers truncate to their format width with a cast.
    function automatic logic [QNAN_MAX_W-1:0] canon_qnan(input int exp_w, input int man_w);
        logic [QNAN_MAX_W-1:0] r;
        r = ((QNAN_MAX_W'(1) << exp_w) - QNAN_MAX_W'(1)) << man_w;
        r = r | (QNAN_MAX_W'(1) << (man_w - 1));
        return r;
    endfunction

endpackage

// File: rtl/fp_classify.sv
// Operand classifier: NORM / ZERO / INF / QNAN / SNAN from exponent and mantissa.
// Latency: combinational. Backpressure: none (pure function of the input).
// Ports: mag_i = operand without its sign bit; cls_o = class.
// Macro FP_SPECIAL_DAZ_EN: when defined, subnormals classify as zero.
module fp_classify
    import fp_special_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic [EXP_W+MAN_W-1:0] mag_i,
    output fp_class_e              cls_o
);

    logic [EXP_W-1:0] exp_f;
    logic [MAN_W-1:0] man_f;

    assign exp_f = mag_i[MAN_W +: EXP_W];
    assign man_f = mag_i[MAN_W-1:0];

    always_comb begin
        cls_o = CLS_NORM;
        if (&exp_f) begin
            if (man_f == '0)
                cls_o = CLS_INF;
            else if (man_f[MAN_W-1])
                cls_o = CLS_QNAN;
            else
                cls_o = CLS_SNAN;
        end else if (exp_f == '0) begin
`ifdef FP_SPECIAL_DAZ_EN
            // Denormals are flushed: any zero-exponent value counts as zero.
            cls_o = CLS_ZERO;
`else
            // Subnormals stay ordinary values and go through the adder.
            if (man_f == '0)
                cls_o = CLS_ZERO;
`endif
        end
    end

endmodule

// File: rtl/fp_addsub_special_pipe.sv
// Special-operand resolver for IEEE-754 add/sub; flags results that bypass the adder.
// Latency 2 cycles (classify, resolve), 1 op/cycle throughput.
// Backpressure: valid/ready, in_ready = !v1 || !v2 || out_ready; stalled stages hold.
// Ports: in_* operation (a, b, op 0=add 1=sub, rm, tag) with in_valid/in_ready;
//        out_* resolved result, special, invalid, tag with out_valid/out_ready;
//        special_cnt saturating count of delivered special results.
// Macro FP_SPECIAL_DAZ_EN: denormal operands are treated as signed zeros.
module fp_addsub_special_pipe
    import fp_special_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int TAG_W = 4,
    parameter int CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EXP_W+MAN_W:0]   in_a,
    input  logic [EXP_W+MAN_W:0]   in_b,
    input  logic                   in_op,
    input  logic [1:0]             in_rm,
    input  logic [TAG_W-1:0]       in_tag,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W:0]   out_result,
    output logic                   out_special,
    output logic                   out_invalid,
    output logic [TAG_W-1:0]       out_tag,
    output logic [CNT_W-1:0]       special_cnt
);

    localparam int W = 1 + EXP_W + MAN_W;
    localparam logic [W-1:0] QNAN = W'(canon_qnan(EXP_W, MAN_W));

    // Stage 1: classes, A, B with its effective sign folded in, rm, tag.
    logic             v1_q;
    fp_class_e        cls_a_q, cls_b_q;
    logic [W-1:0]     a_q, b_q;
    logic [1:0]       rm_q;
    logic [TAG_W-1:0] tag1_q;

    // Stage 2: resolved output.
    logic             v2_q;
    logic [W-1:0]     res_q, res_d;
    logic             spec_q, spec_d;
    logic             inv_q, inv_d;
    logic [TAG_W-1:0] tag2_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    fp_class_e        cls_a_w, cls_b_w;
    logic             adv1, adv2;

    assign adv2     = !v2_q || out_ready;
    assign adv1     = !v1_q || adv2;
    assign in_ready = adv1;

    fp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls_a (
        .mag_i (in_a[W-2:0]),
        .cls_o (cls_a_w)
    );

    fp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls_b (
        .mag_i (in_b[W-2:0]),
        .cls_o (cls_b_w)
    );

    // Resolution from stage-1 state; first matching rule wins.
    logic a_nan, b_nan, a_snan, b_snan, sa, sb, zsign;
    always_comb begin
        a_snan = (cls_a_q == CLS_SNAN);
        b_snan = (cls_b_q == CLS_SNAN);
        a_nan  = a_snan || (cls_a_q == CLS_QNAN);
        b_nan  = b_snan || (cls_b_q == CLS_QNAN);
        sa     = a_q[W-1];
        sb     = b_q[W-1];
        // Exact cancellation of opposite-signed zeros is +0 except rounding down.
        zsign  = (sa == sb) ? sa : (rm_q == RM_RDN);
        res_d  = '0;
        spec_d = 1'b1;
        inv_d  = 1'b0;
        if (a_nan || b_nan) begin
            res_d = QNAN;
            inv_d = a_snan || b_snan;
        end else if (cls_a_q == CLS_INF && cls_b_q == CLS_INF && sa != sb) begin
            res_d = QNAN;
            inv_d = 1'b1;
        end else if (cls_a_q == CLS_INF) begin
            res_d = a_q;
        end else if (cls_b_q == CLS_INF) begin
            res_d = b_q;
        end else if (cls_a_q == CLS_ZERO && cls_b_q == CLS_ZERO) begin
            res_d = {zsign, {(W-1){1'b0}}};
        end else if (cls_a_q == CLS_ZERO) begin
            res_d = b_q;
        end else if (cls_b_q == CLS_ZERO) begin
            res_d = a_q;
        end else begin
            spec_d = 1'b0;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (out_valid && out_ready && out_special && cnt_q != {CNT_W{1'b1}})
            cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q    <= 1'b0;
            cls_a_q <= CLS_NORM;
            cls_b_q <= CLS_NORM;
            a_q     <= '0;
            b_q     <= '0;
            rm_q    <= RM_RNE;
            tag1_q  <= '0;
            v2_q    <= 1'b0;
            res_q   <= '0;
            spec_q  <= 1'b0;
            inv_q   <= 1'b0;
            tag2_q  <= '0;
            cnt_q   <= '0;
        end else begin
            if (adv1) begin
                v1_q <= in_valid;
                if (in_valid) begin
                    cls_a_q <= cls_a_w;
                    cls_b_q <= cls_b_w;
                    a_q     <= in_a;
                    b_q     <= {in_b[W-1] ^ in_op, in_b[W-2:0]};
                    rm_q    <= in_rm;
                    tag1_q  <= in_tag;
                end
            end
            if (adv2) begin
                v2_q <= v1_q;
                if (v1_q) begin
                    res_q  <= res_d;
                    spec_q <= spec_d;
                    inv_q  <= inv_d;
                    tag2_q <= tag1_q;
                end
            end
            cnt_q <= cnt_d;
        end
    end

    assign out_valid   = v2_q;
    assign out_result  = res_q;
    assign out_special = spec_q;
    assign out_invalid = inv_q;
    assign out_tag     = tag2_q;
    assign special_cnt = cnt_q;

endmodule

// File: tb/tb_fp_addsub_special_pipe.sv
// Bench for fp_addsub_special_pipe (binary32, 4-bit tag, 4-bit counter).
// Directed cases, a backpressure case, random traffic against a reference model,
// counter saturation and mid-stream reset.
module tb_fp_addsub_special_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, in_op, out_valid, out_ready;
    logic [31:0] in_a, in_b, out_result;
    logic [1:0]  in_rm;
    logic [3:0]  in_tag, out_tag, special_cnt;
    logic        out_special, out_invalid;

    int n_cmp = 0;
    int n_err = 0;
    int n_acc = 0;
    int stab_err = 0;

    logic [37:0] exp_q[$];
    logic [37:0] got_q[$];

    always #5 clk = ~clk;

    fp_addsub_special_pipe #(.EXP_W(8), .MAN_W(23), .TAG_W(4), .CNT_W(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_a        (in_a),
        .in_b        (in_b),
        .in_op       (in_op),
        .in_rm       (in_rm),
        .in_tag      (in_tag),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_result  (out_result),
        .out_special (out_special),
        .out_invalid (out_invalid),
        .out_tag     (out_tag),
        .special_cnt (special_cnt)
    );

    // 0 ordinary, 1 zero, 2 infinity, 3 quiet NaN, 4 signalling NaN
    function automatic int kind(input logic [31:0] x);
        if (x[30:23] == 8'hFF) begin
            if (x[22:0] == 23'd0) return 2;
            return x[22] ? 3 : 4;
        end
`ifdef FP_SPECIAL_DAZ_EN
        if (x[30:23] == 8'h00) return 1;
`else
        if (x[30:0] == 31'd0) return 1;
`endif
        return 0;
    endfunction

    // Returns {invalid, special, result}.
    function automatic logic [33:0] ref_model(input logic [31:0] a, input logic [31:0] b,
                                              input logic op, input logic [1:0] rm);
        int ka, kb;
        logic sa, sb, s;
        ka = kind(a);
        kb = kind(b);
        sa = a[31];
        sb = b[31] ^ op;
        if (ka >= 3 || kb >= 3) return {(ka == 4 || kb == 4), 1'b1, 32'h7FC00000};
        if (ka == 2 && kb == 2 && sa != sb) return {2'b11, 32'h7FC00000};
        if (ka == 2) return {2'b01, sa, 31'h7F800000};
        if (kb == 2) return {2'b01, sb, 31'h7F800000};
        if (ka == 1 && kb == 1) begin
            s = (sa == sb) ? sa : (rm == 2'd2);
            return {2'b01, s, 31'd0};
        end
        if (ka == 1) return {2'b01, sb, b[30:0]};
        if (kb == 1) return {2'b01, a};
        return 34'd0;
    endfunction

    function automatic logic [31:0] pick();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 7))
            0: r = {r[31], 31'd0};
            1: r = {r[31], 31'h7F800000};
            2: r = {r[31], 8'hFF, 1'b1, r[21:0]};
            3: r = {r[31], 8'hFF, 1'b0, r[21:1], 1'b1};
            4: r = {r[31], 8'h00, r[22:0]};
            default: ;
        endcase
        return r;
    endfunction

    // Scoreboard capture and output-stability watch.
    logic        stall_prev = 1'b0;
    logic [38:0] out_prev = '0;
    always @(posedge clk) begin
        if (!rst) begin
            if (stall_prev && {out_valid, out_tag, out_invalid, out_special, out_result} != out_prev)
                stab_err++;
            if (in_valid && in_ready) begin
                n_acc++;
                exp_q.push_back({in_tag, ref_model(in_a, in_b, in_op, in_rm)});
            end
            if (out_valid && out_ready)
                got_q.push_back({out_tag, out_invalid, out_special, out_result});
        end
        stall_prev = out_valid && !out_ready && !rst;
        out_prev   = {out_valid, out_tag, out_invalid, out_special, out_result};
    end

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] req);
        n_cmp++;
        assert (obs === req) else begin
            n_err++;
            $error("FAIL %s: observed %0h required %0h", name, obs, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_one(input string nm, input logic [31:0] a, input logic [31:0] b,
                          input logic op, input logic [1:0] rm, input logic [3:0] tg,
                          input logic [31:0] er, input logic es, input logic ei);
        int start;
        start    = n_acc;
        in_a     = a;
        in_b     = b;
        in_op    = op;
        in_rm    = rm;
        in_tag   = tg;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check({nm, " accepted"}, 64'(n_acc - start), 64'd1);
        check({nm, " not yet valid"}, 64'(out_valid), 64'd0);
        tick();
        check({nm, " valid"}, 64'(out_valid), 64'd1);
        check({nm, " result"}, 64'(out_result), 64'(er));
        check({nm, " special"}, 64'(out_special), 64'(es));
        check({nm, " invalid"}, 64'(out_invalid), 64'(ei));
        check({nm, " tag"}, 64'(out_tag), 64'(tg));
        tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        int start, sent, prev, nspec, nmin;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        in_a = '0; in_b = '0; in_op = 1'b0; in_rm = 2'd0; in_tag = '0;
        repeat (3) tick();
        check("rst out_valid", 64'(out_valid), 64'd0);
        check("rst out_result", 64'(out_result), 64'd0);
        check("rst out_special", 64'(out_special), 64'd0);
        check("rst out_invalid", 64'(out_invalid), 64'd0);
        check("rst out_tag", 64'(out_tag), 64'd0);
        check("rst special_cnt", 64'(special_cnt), 64'd0);
        rst = 1'b0;
        tick();
        check("idle in_ready", 64'(in_ready), 64'd1);

        // Directed cases.
        do_one("z-z rne", 32'h00000000, 32'h00000000, 1'b1, 2'd0, 4'd1, 32'h00000000, 1'b1, 1'b0);
        do_one("z-z rdn", 32'h00000000, 32'h00000000, 1'b1, 2'd2, 4'd2, 32'h80000000, 1'b1, 1'b0);
        do_one("-z+-z", 32'h80000000, 32'h80000000, 1'b0, 2'd0, 4'd3, 32'h80000000, 1'b1, 1'b0);
        do_one("z+-z rup", 32'h00000000, 32'h80000000, 1'b0, 2'd3, 4'd4, 32'h00000000, 1'b1, 1'b0);
        do_one("inf-inf", 32'h7F800000, 32'h7F800000, 1'b1, 2'd0, 4'd5, 32'h7FC00000, 1'b1, 1'b1);
        do_one("inf+inf", 32'h7F800000, 32'h7F800000, 1'b0, 2'd0, 4'd6, 32'h7F800000, 1'b1, 1'b0);
        do_one("snan", 32'h7F800001, 32'h3F800000, 1'b0, 2'd0, 4'd7, 32'h7FC00000, 1'b1, 1'b1);
        do_one("qnan", 32'h7FC00005, 32'h3F800000, 1'b0, 2'd0, 4'd8, 32'h7FC00000, 1'b1, 1'b0);
        do_one("1-inf", 32'h3F800000, 32'h7F800000, 1'b1, 2'd0, 4'd9, 32'hFF800000, 1'b1, 1'b0);
        do_one("z-b", 32'h00000000, 32'h3F800000, 1'b1, 2'd0, 4'd10, 32'hBF800000, 1'b1, 1'b0);
        do_one("a--z", 32'hC0400000, 32'h80000000, 1'b1, 2'd0, 4'd11, 32'hC0400000, 1'b1, 1'b0);
        do_one("normal", 32'h3F800000, 32'h40000000, 1'b0, 2'd0, 4'd12, 32'h00000000, 1'b0, 1'b0);
`ifdef FP_SPECIAL_DAZ_EN
        do_one("subn", 32'h00000001, 32'h00000001, 1'b1, 2'd0, 4'd13, 32'h00000000, 1'b1, 1'b0);
`else
        do_one("subn", 32'h00000001, 32'h00000001, 1'b1, 2'd0, 4'd13, 32'h00000000, 1'b0, 1'b0);
`endif

        // Backpressure: three tags offered while the output is blocked.
        exp_q.delete(); got_q.delete();
        out_ready = 1'b0;
        start = n_acc;
        in_a = 32'h00000000; in_b = 32'h3F800000; in_op = 1'b0; in_rm = 2'd0;
        in_tag = 4'd1; in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            if (n_acc - start < 3) in_tag = 4'(n_acc - start + 1);
        end
        check("stall accepted", 64'(n_acc - start), 64'd2);
        check("stall in_ready", 64'(in_ready), 64'd0);
        check("stall out_tag", 64'(out_tag), 64'd1);
        out_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            if (n_acc - start >= 3) in_valid = 1'b0;
            tick();
        end
        in_valid = 1'b0;
        check("stall delivered", 64'(got_q.size()), 64'd3);
        for (int i = 0; i < 3 && i < got_q.size(); i++)
            check("stall order", 64'(got_q[i][37:34]), 64'(i + 1));
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            check("stall data", 64'(got_q[i]), 64'(exp_q[i]));

        // Random traffic with random backpressure.
        do_reset();
        exp_q.delete(); got_q.delete();
        sent = 0;
        prev = n_acc;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            if (!in_valid || n_acc != prev) begin
                prev = n_acc;
                if (sent < 200 && $urandom_range(0, 4) != 0) begin
                    in_a = pick(); in_b = pick();
                    in_op = 1'($urandom); in_rm = 2'($urandom); in_tag = 4'($urandom);
                    in_valid = 1'b1;
                    sent++;
                end else begin
                    in_valid = 1'b0;
                end
            end
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (10) tick();
        check("random accepted", 64'(exp_q.size()), 64'd200);
        check("random delivered", 64'(got_q.size()), 64'(exp_q.size()));
        nmin = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        nspec = 0;
        for (int i = 0; i < nmin; i++) begin
            check("random item", 64'(got_q[i]), 64'(exp_q[i]));
            if (exp_q[i][32]) nspec++;
        end
        check("random special_cnt", 64'(special_cnt), 64'((nspec > 15) ? 15 : nspec));
        check("output stable while stalled", 64'(stab_err), 64'd0);

        // Counter: 7 then 20 specials back to back.
        do_reset();
        in_a = 32'h00000000; in_b = 32'h00000000; in_op = 1'b0; in_rm = 2'd0; in_tag = 4'd0;
        in_valid = 1'b1;
        repeat (7) tick();
        in_valid = 1'b0;
        repeat (3) tick();
        check("cnt after 7", 64'(special_cnt), 64'd7);
        in_valid = 1'b1;
        repeat (13) tick();
        in_valid = 1'b0;
        repeat (3) tick();
        check("cnt saturated", 64'(special_cnt), 64'd15);

        // Reset in the middle of a stream.
        in_valid = 1'b1;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        check("midrst out_valid", 64'(out_valid), 64'd0);
        check("midrst special_cnt", 64'(special_cnt), 64'd0);
        rst = 1'b0;
        in_valid = 1'b0;
        repeat (3) tick();
        check("midrst drained", 64'(out_valid), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
